// File: rtl/openram_arb_ctrl.sv
// rtl/openram_arb_ctrl.sv - two-requester round-robin arbiter driving a single-port OpenRAM macro.
// Macro strobes come straight from flops; responses are one-hot, one-cycle pulses.
module openram_arb_ctrl #(
   parameter int DataWidth   = 32,
   parameter int AddrWidth   = 32,
   parameter int ReadLatency = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             reqValid,
   output logic [1:0]             reqReady,
   input  logic [1:0]             reqWrite,
   input  logic [2*AddrWidth-1:0] reqAddr,
   input  logic [2*DataWidth-1:0] reqWData,
   output logic [1:0]             respValid,
   output logic [DataWidth-1:0]   respRData,
   output logic                   busy,
   output logic [AddrWidth-1:0]   addr,
   output logic [DataWidth-1:0]   dataIn,
   output logic                   CS_B,
   output logic                   WE_B,
   output logic                   OE_B,
   input  logic [DataWidth-1:0]   dataOut
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      READWAIT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic                   owner_q, owner_d;
   logic                   write_q, write_d;
   logic                   last_grant_q, last_grant_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [DataWidth-1:0]   data_in_q, data_in_d;
   logic                   cs_b_q, cs_b_d;
   logic                   we_b_q, we_b_d;
   logic                   oe_b_q, oe_b_d;
   logic [1:0]             resp_valid_q, resp_valid_d;
   logic [DataWidth-1:0]   resp_rdata_q, resp_rdata_d;
   logic [1:0]             ready;
   logic                   win;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      write_d      = write_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      data_in_d    = data_in_q;
      cs_b_d       = cs_b_q;
      we_b_d       = we_b_q;
      oe_b_d       = oe_b_q;
      resp_valid_d = 2'b00;
      resp_rdata_d = resp_rdata_q;
      ready        = 2'b00;
      // On a tie the requester that was not granted last wins.
      win          = (reqValid == 2'b11) ? ~last_grant_q : reqValid[1];

      case (state_q)
         IDLE: begin
            if (!reset) begin
               ready = (win ? 2'b10 : 2'b01) & reqValid;
            end
            if (ready != 2'b00) begin
               owner_d      = win;
               write_d      = reqWrite[win];
               last_grant_d = win;
               addr_d       = win ? reqAddr[2*AddrWidth-1:AddrWidth] : reqAddr[AddrWidth-1:0];
               data_in_d    = win ? reqWData[2*DataWidth-1:DataWidth] : reqWData[DataWidth-1:0];
               cs_b_d       = 1'b0;
               we_b_d       = ~reqWrite[win];
               oe_b_d       = reqWrite[win];
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            cs_b_d = 1'b1;
            if (write_q) begin
               we_b_d       = 1'b1;
               resp_valid_d = owner_q ? 2'b10 : 2'b01;
               resp_rdata_d = '0;
               state_d      = IDLE;
            end else begin
               cnt_d   = 3'd0;
               state_d = READWAIT;
            end
         end
         READWAIT: begin
            if (cnt_q == 3'(ReadLatency - 1)) begin
               resp_rdata_d = dataOut;
               resp_valid_d = owner_q ? 2'b10 : 2'b01;
               oe_b_d       = 1'b1;
               cnt_d        = 3'd0;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         write_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= 3'd0;
         addr_q       <= '0;
         data_in_q    <= '0;
         cs_b_q       <= 1'b1;
         we_b_q       <= 1'b1;
         oe_b_q       <= 1'b1;
         resp_valid_q <= 2'b00;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         write_q      <= write_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         data_in_q    <= data_in_d;
         cs_b_q       <= cs_b_d;
         we_b_q       <= we_b_d;
         oe_b_q       <= oe_b_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign reqReady  = ready;
   assign respValid = resp_valid_q;
   assign respRData = resp_rdata_q;
   assign busy      = (state_q != IDLE);
   assign addr      = addr_q;
   assign dataIn    = data_in_q;
   assign CS_B      = cs_b_q;
   assign WE_B      = we_b_q;
   assign OE_B      = oe_b_q;

endmodule

// File: tb/tb_openram_arb_ctrl.sv
// tb/tb_openram_arb_ctrl.sv - cycle-stepped bench for openram_arb_ctrl with a transaction-level model.
module tb_openram_arb_ctrl;

   localparam int RL = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  reqValid = 2'b00;
   logic [1:0]  reqReady;
   logic [1:0]  reqWrite = 2'b00;
   logic [63:0] reqAddr = '0;
   logic [63:0] reqWData = '0;
   logic [1:0]  respValid;
   logic [31:0] respRData;
   logic        busy;
   logic [31:0] addr;
   logic [31:0] dataIn;
   logic        CS_B, WE_B, OE_B;
   logic [31:0] dataOut;

   openram_arb_ctrl #(.DataWidth(32), .AddrWidth(32), .ReadLatency(RL)) dut (
      .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
      .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWData(reqWData),
      .respValid(respValid), .respRData(respRData), .busy(busy),
      .addr(addr), .dataIn(dataIn), .CS_B(CS_B), .WE_B(WE_B), .OE_B(OE_B),
      .dataOut(dataOut)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] seed(input logic [3:0] i);
      return 32'hC0DE_0000 + {28'h0, i} * 32'h0101_0011;
   endfunction

   // Macro model: 16 words, data only valid RL cycles after the select.
   logic [31:0] mem [16];
   logic [15:0] written = '0;
   logic [3:0]  since = 4'd0;
   always @(posedge clk) begin
      if (!CS_B && !WE_B) begin
         mem[addr[3:0]]     <= dataIn;
         written[addr[3:0]] <= 1'b1;
      end
      if (!CS_B) since <= 4'd1;
      else if (since != 4'hF) since <= since + 4'd1;
   end
   assign dataOut = (!OE_B && since >= 4'(RL)) ?
                    (written[addr[3:0]] ? mem[addr[3:0]] : seed(addr[3:0])) : 32'hBAD0_BAD0;

   int checks = 0;
   int failures = 0;

   // Transaction-level reference state.
   int          cyc = 0;
   bit          act = 1'b0;
   int          hs_cyc = 0;
   int          free_cyc = 0;
   bit          m_owner, m_write;
   bit          m_last = 1'b1;
   bit          rst_prev = 1'b1;
   logic [31:0] m_rexp = '0;
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_din = '0;
   logic [31:0] ref_mem [16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input logic [1:0] v, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
      logic [1:0]  exp_ready, exp_resp;
      logic        win;
      logic [31:0] wa, wd;
      bit          idle, in_access;
      @(posedge clk);
      #1;
      cyc++;
      reset    = rst;
      reqValid = v;
      reqWrite = w;
      reqAddr  = {a1, a0};
      reqWData = {d1, d0};
      #3;
      idle      = !act || (cyc >= free_cyc);
      in_access = act && (cyc == hs_cyc + 1);
      win       = (v == 2'b11) ? ~m_last : v[1];
      exp_ready = (idle && !rst) ? ((win ? 2'b10 : 2'b01) & v) : 2'b00;
      exp_resp  = (act && cyc == free_cyc) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      chk("reqReady", reqReady, exp_ready);
      chk("respValid", respValid, exp_resp);
      if (exp_resp != 2'b00) chk("respRData", respRData, m_write ? 32'h0 : m_rexp);
      if (rst_prev) chk("rst_respRData", respRData, 32'h0);
      chk("CS_B", CS_B, !in_access);
      chk("WE_B", WE_B, !(in_access && m_write));
      chk("OE_B", OE_B, !(act && !m_write && cyc >= hs_cyc + 1 && cyc <= hs_cyc + 1 + RL));
      chk("busy", busy, act && cyc > hs_cyc && cyc < free_cyc);
      chk("addr", addr, exp_addr);
      chk("dataIn", dataIn, exp_din);

      rst_prev = rst;
      if (rst) begin
         act      = 1'b0;
         m_last   = 1'b1;
         exp_addr = '0;
         exp_din  = '0;
      end else if (exp_ready != 2'b00) begin
         wa       = win ? a1 : a0;
         wd       = win ? d1 : d0;
         act      = 1'b1;
         hs_cyc   = cyc;
         m_owner  = win;
         m_write  = w[win];
         m_last   = win;
         free_cyc = cyc + (m_write ? 2 : RL + 2);
         exp_addr = wa;
         exp_din  = wd;
         if (m_write) ref_mem[wa[3:0]] = wd;
         else m_rexp = ref_mem[wa[3:0]];
      end
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = seed(4'(i));
      repeat (2) @(posedge clk);

      // Reset values and ready held low under reset, even with requests present.
      step(1'b1, 2'b11, 2'b00, 32'h1, 32'h2, 32'h3, 32'h4);
      step(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

      // Single write from requester 0, then read it back from requester 1.
      step(1'b0, 2'b01, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0);
      idle_steps(3);
      step(1'b0, 2'b10, 2'b00, 32'h0, 32'h10, 32'h0, 32'h0);
      idle_steps(RL + 3);

      // Both requesters valid continuously: alternation, hold-off, back-to-back.
      for (int i = 0; i < 40; i++)
         step(1'b0, 2'b11, 2'($urandom_range(0, 3)), $urandom(), $urandom(), $urandom(), $urandom());
      idle_steps(RL + 3);

      // Reset in READWAIT aborts the read; tie afterwards goes to requester 0.
      step(1'b0, 2'b01, 2'b00, 32'h5, 32'h0, 32'h0, 32'h0);
      idle_steps(2);
      step(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      idle_steps(RL + 3);
      for (int i = 0; i < 2 * (RL + 2); i++)
         step(1'b0, 2'b11, 2'b00, 32'h5, 32'h10, 32'h0, 32'h0);
      idle_steps(RL + 3);

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 63) == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              $urandom(), $urandom(), $urandom(), $urandom());
      idle_steps(RL + 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
